// File: rtl/pps_qualifier.sv
// Synchronises raw PPS, measures edge-to-edge period, qualifies edges into a one-cycle o_pps plus lock status.
// o_pps lands 3 clocks after i_pps is first sampled high; no backpressure. Flywheel/holdover enabled by PPS_FLYWHEEL_EN.
module pps_qualifier #(
  parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
  parameter int unsigned TOLERANCE     = 5_000,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned HOLDOVER_SECS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pps,
  output logic        o_pps,
  output logic [31:0] o_period,
  output logic        o_locked,
  output logic        o_missing
);

  localparam logic [31:0] P_MIN  = 32'(CLOCK_RATE_HZ - TOLERANCE);
  localparam logic [31:0] P_MAX  = 32'(CLOCK_RATE_HZ + TOLERANCE);
  localparam logic [31:0] P_TMO  = P_MAX - 32'd1;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_COUNT);

`ifdef PPS_FLYWHEEL_EN
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, HOLDOVER} state_t;
  localparam logic [31:0] FLY_FIRST = 32'(2 * CLOCK_RATE_HZ - 1);
  localparam logic [31:0] FLY_NEXT  = 32'(CLOCK_RATE_HZ - 1);
  localparam logic [15:0] HOLD_N    = 16'(HOLDOVER_SECS);
`else
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2, r_sync3, r_edge;
  logic [31:0] r_cnt;
  logic [3:0]  r_good, w_good_nxt, w_good_inc;
  logic        w_pps_nxt, w_missing_nxt, w_edge, w_timeout, w_valid, w_locked_now;
  logic [31:0] w_period;
`ifdef PPS_FLYWHEEL_EN
  logic [31:0] r_fly;
  logic [15:0] r_nsynth, w_nsynth_inc;
  logic        w_fly_due;
`endif

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_period   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
  assign w_valid    = (w_period >= P_MIN) && (w_period <= P_MAX);
  // An edge landing on the timeout cycle wins, so P_MAX itself stays valid.
  assign w_timeout  = (r_cnt == P_TMO) && !r_edge;
  assign w_good_inc = r_good + 4'd1;

`ifdef PPS_FLYWHEEL_EN
  assign w_locked_now = (r_state == LOCKED) || (r_state == HOLDOVER);
  assign w_nsynth_inc = r_nsynth + 16'd1;
  assign w_fly_due    = (r_nsynth == 16'd0) ? (r_fly == FLY_FIRST) : (r_fly == FLY_NEXT);
`else
  assign w_locked_now = (r_state == LOCKED);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= SEARCH;
      r_good    <= 4'd0;
      o_pps     <= 1'b0;
      o_missing <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_good    <= w_good_nxt;
      o_pps     <= w_pps_nxt;
      o_missing <= w_missing_nxt;
      o_locked  <= w_locked_now;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good;
    w_pps_nxt     = 1'b0;
    w_missing_nxt = 1'b0;
    case (r_state)
      SEARCH: begin
        if (r_edge) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (r_edge) begin
          if (w_valid) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_N) begin
              w_state_nxt = LOCKED;
              w_pps_nxt   = 1'b1;
            end
          end else begin
            w_good_nxt = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_nxt = SEARCH;
        end
      end
      LOCKED: begin
        if (r_edge) begin
          if (w_valid) begin
            w_pps_nxt = 1'b1;
          end else begin
            w_state_nxt = ACQUIRE;
            w_good_nxt  = 4'd0;
          end
        end else if (w_timeout) begin
          w_missing_nxt = 1'b1;
`ifdef PPS_FLYWHEEL_EN
          w_state_nxt   = HOLDOVER;
`else
          w_state_nxt   = SEARCH;
`endif
        end
      end
`ifdef PPS_FLYWHEEL_EN
      HOLDOVER: begin
        if (r_edge) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 4'd0;
        end else if (w_fly_due) begin
          w_pps_nxt = 1'b1;
          if (w_nsynth_inc == HOLD_N) w_state_nxt = SEARCH;
        end
      end
`endif
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_edge   <= 1'b0;
      r_cnt    <= 32'd0;
      o_period <= 32'd0;
    end else begin
      r_sync1 <= i_pps;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= w_edge;
      if (r_edge) begin
        r_cnt    <= 32'd0;
        o_period <= w_period;
      end else if (r_cnt != 32'hFFFF_FFFF) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

`ifdef PPS_FLYWHEEL_EN
  // r_fly times from the last emitted second, real or synthetic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fly    <= 32'd0;
      r_nsynth <= 16'd0;
    end else begin
      if (w_pps_nxt) r_fly <= 32'd0;
      else if (r_fly != 32'hFFFF_FFFF) r_fly <= r_fly + 32'd1;
      if (r_state != HOLDOVER) r_nsynth <= 16'd0;
      else if (w_pps_nxt) r_nsynth <= w_nsynth_inc;
    end
  end
`endif

endmodule

// File: tb/tb_pps_qualifier.sv
// Bench for pps_qualifier: edge table plus reset, loss and holdover sequences, with o_pps/o_missing timing scoreboards.
module tb_pps_qualifier;
  localparam int CR  = 1000;
  localparam int TOL = 10;
  localparam int LC  = 3;
  localparam int HS  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pps;
  logic        o_pps;
  logic [31:0] o_period;
  logic        o_locked;
  logic        o_missing;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_miss_seen = 0;
  int ppsq[$];
  int missq[$];
  int last_rise = 0;
  int cur_width = 100;
  int exp_c;

  typedef struct {
    int gap;
    int width;
    bit pps;
    bit miss;
    int period;
    bit locked;
  } row_t;
  row_t tbl[19];

  pps_qualifier #(
    .CLOCK_RATE_HZ(CR), .TOLERANCE(TOL), .LOCK_COUNT(LC), .HOLDOVER_SECS(HS)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_pps(pps),
    .o_pps(o_pps), .o_period(o_period), .o_locked(o_locked), .o_missing(o_missing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (o_pps === 1'b1) begin
      if (ppsq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pps_unexpected: o_pps high at cycle %0d, expected low", cyc);
      end else begin
        exp_c = ppsq.pop_front();
        check("pps_cycle", cyc, exp_c);
      end
    end
    if (o_missing === 1'b1) begin
      n_miss_seen++;
      if (missq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL missing_unexpected: o_missing high at cycle %0d, expected low", cyc);
      end else begin
        exp_c = missq.pop_front();
        check("missing_cycle", cyc, exp_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (cyc >= last_rise + cur_width) pps = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic run_row(input int idx);
    row_t r;
    r = tbl[idx];
    if (r.miss) missq.push_back(last_rise + CR + TOL + 4);
    wait_until(last_rise + r.gap);
    pps = 1'b1;
    last_rise = cyc;
    cur_width = r.width;
    if (r.pps) ppsq.push_back(cyc + 4);
    wait_until(last_rise + 6);
    if (r.period >= 0) check($sformatf("row%0d_period", idx), o_period, r.period);
    check($sformatf("row%0d_locked", idx), {31'd0, o_locked}, {31'd0, r.locked});
  endtask

  task automatic relock();
    last_rise = cyc;
    for (int i = 0; i < 4; i++) run_row(i);
  endtask

  initial begin
    int base;
    int miss_before;
    //            gap   width pps miss period locked
    tbl[0]  = '{20,   100, 1'b0, 1'b0, -1,   1'b0};
    tbl[1]  = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[2]  = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[3]  = '{1000, 100, 1'b1, 1'b0, 1000, 1'b1};
    tbl[4]  = '{990,  100, 1'b1, 1'b0, 990,  1'b1};
    tbl[5]  = '{1010, 100, 1'b1, 1'b0, 1010, 1'b1};
    tbl[6]  = '{989,  100, 1'b0, 1'b0, 989,  1'b0};
    tbl[7]  = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[8]  = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[9]  = '{1000, 100, 1'b1, 1'b0, 1000, 1'b1};
    tbl[10] = '{300,  2,   1'b0, 1'b0, 300,  1'b0};
    tbl[11] = '{700,  100, 1'b0, 1'b0, 700,  1'b0};
    tbl[12] = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[13] = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[14] = '{1000, 100, 1'b1, 1'b0, 1000, 1'b1};
    tbl[15] = '{1011, 100, 1'b0, 1'b1, 1011, 1'b0};
    tbl[16] = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[17] = '{1000, 100, 1'b0, 1'b0, 1000, 1'b0};
    tbl[18] = '{1000, 100, 1'b1, 1'b0, 1000, 1'b1};

    rst = 1'b1;
    pps = 1'b0;
    repeat (3) tick();
    check("rst_pps", {31'd0, o_pps}, 32'd0);
    check("rst_period", o_period, 32'd0);
    check("rst_locked", {31'd0, o_locked}, 32'd0);
    check("rst_missing", {31'd0, o_missing}, 32'd0);
    rst = 1'b0;
    tick();

    last_rise = cyc;
    for (int i = 0; i < 19; i++) run_row(i);

    // Reset mid-period while locked, with the input toggling.
    wait_until(last_rise + 500);
    rst = 1'b1;
    pps = 1'b1;
    #1;
    check("midrst_pps", {31'd0, o_pps}, 32'd0);
    check("midrst_period", o_period, 32'd0);
    check("midrst_locked", {31'd0, o_locked}, 32'd0);
    check("midrst_missing", {31'd0, o_missing}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      pps = (i % 3) != 0;
    end
    pps = 1'b0;
    tick();
    rst = 1'b0;
    repeat (100) tick();
    check("postrst_period", o_period, 32'd0);
    check("postrst_locked", {31'd0, o_locked}, 32'd0);

    // Reference lost while locked, input held low.
    relock();
    base = last_rise;
    miss_before = n_miss_seen;
    missq.push_back(base + CR + TOL + 4);
`ifdef PPS_FLYWHEEL_EN
    ppsq.push_back(base + 4 + 2 * CR);
    ppsq.push_back(base + 4 + 3 * CR);
    wait_until(base + 1100);
    check("hold_locked_early", {31'd0, o_locked}, 32'd1);
    wait_until(base + 2500);
    check("hold_locked_mid", {31'd0, o_locked}, 32'd1);
`endif
    wait_until(base + 3500);
    check("loss_locked", {31'd0, o_locked}, 32'd0);
    check("loss_miss_count", n_miss_seen, miss_before + 1);

`ifdef PPS_FLYWHEEL_EN
    // Same loss, but the reference returns during holdover.
    relock();
    base = last_rise;
    missq.push_back(base + CR + TOL + 4);
    ppsq.push_back(base + 4 + 2 * CR);
    wait_until(base + 2500);
    pps = 1'b1;
    last_rise = cyc;
    cur_width = 100;
    wait_until(last_rise + 6);
    check("restore_locked", {31'd0, o_locked}, 32'd0);
    check("restore_period", o_period, 32'd2500);
    wait_until(last_rise + 2000);
    check("restore_locked_late", {31'd0, o_locked}, 32'd0);
`endif

    repeat (10) tick();
    check("pps_queue_drained", ppsq.size(), 32'd0);
    check("missing_queue_drained", missq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
